speed_select_debounce: RTL and testbench

Conditions the raw 2-bit speed-select switches before they reach the rate divider. Synchronises the asynchronous switch inputs into the `ClockIn` domain and debounces them. Presents a glitch-free `Speed` code plus a one-cycle `SpeedChange` pulse. Top level ORs the pulse into the divider/counter restart so a new rate always starts from a clean count.

---
 rtl/speed_select_debounce_pkg.sv | 20 ++
 rtl/speed_select_debounce_if.sv | 24 ++
 rtl/speed_select_debounce_sync2.sv | 27 ++
 rtl/speed_select_debounce.sv | 85 ++++++++
 tb/tb_speed_select_debounce.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/speed_select_debounce_pkg.sv
// Shared definitions for the speed-select path: FSM state encoding and the
// speed codes understood by the rate divider.
package lab_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SPD_FULL    = 2'b00,
        SPD_1HZ     = 2'b01,
        SPD_HALF    = 2'b10,
        SPD_QUARTER = 2'b11
    } speed_e;

    localparam int unsigned DEBOUNCE_MIN = 2;
    localparam int unsigned DEBOUNCE_MAX = 65535;

endpackage

// File: rtl/speed_select_debounce_if.sv
// Switch-side bundle: raw switch code in, debounced code, change pulse and
// busy flag out.
interface speed_select_debounce_if;

    logic [1:0] SwIn;
    logic [1:0] Speed;
    logic       SpeedChange;
    logic       Busy;

    modport master (
        output SwIn,
        input  Speed,
        input  SpeedChange,
        input  Busy
    );

    modport slave (
        input  SwIn,
        output Speed,
        output SpeedChange,
        output Busy
    );

endinterface

// File: rtl/speed_select_debounce_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset;
// also reused for the KEY inputs.
module sync2 #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/speed_select_debounce.sv
// Synchronises and debounces the 2-bit speed switches; commits a new code only
// after it has held for DEBOUNCE_CYCLES synchronised cycles.
module speed_select_debounce
    import lab_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                    ClockIn,
    input  logic                    Reset,
    speed_select_debounce_if.slave  sw
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sw_sync;

    state_e        state_q,  state_d;
    logic [1:0]    speed_q,  speed_d;
    logic [1:0]    cand_q,   cand_d;
    logic [CW-1:0] count_q,  count_d;
    logic          change_q, change_d;

    sync2 #(.WIDTH(2)) u_sync (
        .clk   (ClockIn),
        .rst_n (Reset),
        .d     (sw.SwIn),
        .q     (sw_sync)
    );

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_STABLE;
            speed_q  <= SPD_FULL;
            cand_q   <= '0;
            count_q  <= '0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            cand_q   <= cand_d;
            count_q  <= count_d;
            change_q <= change_d;
        end
    end

    // COUNT branches are priority-ordered: bounce-back beats a new candidate,
    // which beats the commit check.
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        cand_d   = cand_q;
        count_d  = count_q;
        change_d = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (sw_sync != speed_q) begin
                    cand_d  = sw_sync;
                    count_d = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sw_sync == speed_q) begin
                    state_d = ST_STABLE;
                end else if (sw_sync != cand_q) begin
                    cand_d  = sw_sync;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    speed_d  = cand_q;
                    change_d = 1'b1;
                    state_d  = ST_STABLE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    assign sw.Speed       = speed_q;
    assign sw.SpeedChange = change_q;
    assign sw.Busy        = (state_q == ST_COUNT);

endmodule

// File: tb/tb_speed_select_debounce.sv
// Directed bench for speed_select_debounce at DEBOUNCE_CYCLES=16 and =2.
module tb_speed_select_debounce;

    logic clk;
    logic Reset;
    int   checks;
    int   errors;

    speed_select_debounce_if bus16 ();
    speed_select_debounce_if bus2 ();

    speed_select_debounce #(.DEBOUNCE_CYCLES(16)) dut16 (
        .ClockIn (clk),
        .Reset   (Reset),
        .sw      (bus16.slave)
    );

    speed_select_debounce #(.DEBOUNCE_CYCLES(2)) dut2 (
        .ClockIn (clk),
        .Reset   (Reset),
        .sw      (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [1:0] spd, input logic pc, input logic busy);
        chk({tag, " Speed"},       bus16.Speed,              spd);
        chk({tag, " SpeedChange"}, {1'b0, bus16.SpeedChange}, {1'b0, pc});
        chk({tag, " Busy"},        {1'b0, bus16.Busy},        {1'b0, busy});
    endtask

    task automatic chk2(input string tag, input logic [1:0] spd, input logic pc, input logic busy);
        chk({tag, " Speed2"},       bus2.Speed,              spd);
        chk({tag, " SpeedChange2"}, {1'b0, bus2.SpeedChange}, {1'b0, pc});
        chk({tag, " Busy2"},        {1'b0, bus2.Busy},        {1'b0, busy});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        bus16.SwIn = 2'b11;
        bus2.SwIn  = 2'b00;

        // Reset holds outputs cleared even with clock running and SwIn=11
        tick();
        tick();
        chk16("reset", 2'b00, 1'b0, 1'b0);
        chk2("reset", 2'b00, 1'b0, 1'b0);

        Reset = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            chk16($sformatf("rel11 e%0d", e), (e >= 18) ? 2'b11 : 2'b00,
                  (e == 18), (e >= 2 && e <= 17));
        end

        // Return to 00
        bus16.SwIn = 2'b00;
        for (int i = 0; i < 20; i++) tick();
        chk16("back00", 2'b00, 1'b0, 1'b0);

        // 00 -> 01 held
        bus16.SwIn = 2'b01;
        for (int e = 0; e <= 19; e++) begin
            tick();
            chk16($sformatf("step01 e%0d", e), (e >= 18) ? 2'b01 : 2'b00,
                  (e == 18), (e >= 2 && e <= 17));
        end

        bus16.SwIn = 2'b00;
        for (int i = 0; i < 20; i++) tick();
        chk16("back00b", 2'b00, 1'b0, 1'b0);

        // 10 for 5 cycles, then bounce back to 00
        bus16.SwIn = 2'b10;
        for (int e = 0; e <= 25; e++) begin
            tick();
            if (e == 4) bus16.SwIn = 2'b00;
            chk16($sformatf("bounce e%0d", e), 2'b00, 1'b0, (e >= 2 && e <= 6));
        end

        // 01 for 8 cycles, then 10 held: qualification restarts on 10
        bus16.SwIn = 2'b01;
        for (int e = 0; e <= 28; e++) begin
            tick();
            if (e == 7) bus16.SwIn = 2'b10;
            chk16($sformatf("restart e%0d", e), (e >= 26) ? 2'b10 : 2'b00,
                  (e == 26), (e >= 2 && e <= 25));
        end

        // Reset pulse mid-COUNT at count=10
        bus16.SwIn = 2'b01;
        for (int e = 0; e <= 12; e++) tick();
        chk16("precount10", 2'b10, 1'b0, 1'b1);
        Reset = 1'b0;
        #1;
        chk16("async rst", 2'b00, 1'b0, 1'b0);
        tick();
        chk16("in rst", 2'b00, 1'b0, 1'b0);
        Reset = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            chk16($sformatf("requal e%0d", e), (e >= 18) ? 2'b01 : 2'b00,
                  (e == 18), (e >= 2 && e <= 17));
        end

        // DEBOUNCE_CYCLES=2: toggling never commits, ending on a 00 sample
        for (int i = 0; i <= 9; i++) begin
            bus2.SwIn = (i % 2 == 1) ? 2'b00 : 2'b01;
            tick();
            chk($sformatf("toggle Speed2 i%0d", i), bus2.Speed, 2'b00);
            chk($sformatf("toggle SpeedChange2 i%0d", i), {1'b0, bus2.SpeedChange}, 2'b00);
        end
        bus2.SwIn = 2'b11;
        for (int e = 0; e <= 5; e++) begin
            tick();
            chk2($sformatf("hold11 e%0d", e), (e >= 4) ? 2'b11 : 2'b00,
                 (e == 4), (e == 0 || e == 2 || e == 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
